// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes WIDTH-bit operands CHUNK bits per clock,
// LSB chunk first, with the inter-chunk carry held in a register.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic             load, step, last;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a, op_b, part;
  logic [WIDTH-1:0] op_a_next, op_b_next, part_next;
  logic             carry;
  logic [CHUNK:0]   chunk_add;

  // Same-sign operands producing an opposite-sign result; equivalent to
  // carry-into-MSB XOR carry-out-of-MSB on the effective operands.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST_CNT) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Chunk stage: low slices of the shifting operand registers plus the carry.
  assign chunk_add = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry};

  generate
    if (NCHUNK > 1) begin : g_shift
      assign op_a_next = {{CHUNK{1'b0}}, op_a[WIDTH-1:CHUNK]};
      assign op_b_next = {{CHUNK{1'b0}}, op_b[WIDTH-1:CHUNK]};
      assign part_next = {chunk_add[CHUNK-1:0], part[WIDTH-1:CHUNK]};
    end else begin : g_single
      assign op_a_next = '0;
      assign op_b_next = '0;
      assign part_next = chunk_add[CHUNK-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= last;
      if (load)      cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
      if (last) begin
        sum  <= part_next;
        cout <= chunk_add[CHUNK];
        ovf  <= signed_ovf(op_a[CHUNK-1], op_b[CHUNK-1], chunk_add[CHUNK-1]);
      end
    end
  end

  // Operand stage: subtraction folds into ~b with the borrow inverted into the carry.
  always_ff @(posedge clk) begin
    if (load) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= cin ^ sub;
    end else if (step) begin
      op_a  <= op_a_next;
      op_b  <= op_b_next;
      part  <= part_next;
      carry <= chunk_add[CHUNK];
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: directed and random operations compared with an
// arithmetic reference, plus parameter variants.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst, start, sub, cin;
  logic [31:0] a, b;
  logic        busy, done, cout, ovf;
  logic [31:0] sum;

  logic [3:0]  sw_start, sw_busy, sw_done, sw_cout, sw_ovf;
  logic [31:0] sw_a, sw_b;
  logic [31:0] sum_c1, sum_c4, sum_c32;
  logic [15:0] sum_w16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_chunk_adder dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));

  seq_chunk_adder #(.WIDTH(32), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(sw_start[0]), .sub(1'b0), .a(sw_a), .b(sw_b),
    .cin(1'b0), .busy(sw_busy[0]), .done(sw_done[0]), .sum(sum_c1),
    .cout(sw_cout[0]), .ovf(sw_ovf[0]));

  seq_chunk_adder #(.WIDTH(32), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .start(sw_start[1]), .sub(1'b0), .a(sw_a), .b(sw_b),
    .cin(1'b0), .busy(sw_busy[1]), .done(sw_done[1]), .sum(sum_c4),
    .cout(sw_cout[1]), .ovf(sw_ovf[1]));

  seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clk(clk), .rst(rst), .start(sw_start[2]), .sub(1'b0), .a(sw_a), .b(sw_b),
    .cin(1'b0), .busy(sw_busy[2]), .done(sw_done[2]), .sum(sum_c32),
    .cout(sw_cout[2]), .ovf(sw_ovf[2]));

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_w16 (
    .clk(clk), .rst(rst), .start(sw_start[3]), .sub(1'b0), .a(sw_a[15:0]),
    .b(sw_b[15:0]), .cin(1'b0), .busy(sw_busy[3]), .done(sw_done[3]),
    .sum(sum_w16), .cout(sw_cout[3]), .ovf(sw_ovf[3]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {ovf, cout, sum}; cout in subtract mode means "no borrow".
  function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic s);
    logic [32:0] r;
    longint      sv;
    logic        v;
    if (!s) begin
      r  = {1'b0, x} + {1'b0, y} + 33'(ci);
      sv = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    end else begin
      r  = {1'b1, x} - {1'b0, y} - 33'(ci);
      sv = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
    end
    v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return {v, r};
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_main(input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic s, input string tag);
    logic [33:0] e;
    logic [31:0] prev;
    int          lat;
    prev = sum;
    e    = ref_op(x, y, ci, s);
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_held"}, sum, prev);
    wait_done(lat);
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_sum"}, sum, e[31:0]);
    chk({tag, "_cout"}, cout, e[32]);
    chk({tag, "_ovf"}, ovf, e[33]);
    chk({tag, "_busy_end"}, busy, 0);
    tick();
    chk({tag, "_done_drop"}, done, 0);
  endtask

  task automatic run_sweep(input int idx, input logic [31:0] x, input logic [31:0] y,
                           input int explat, input logic [31:0] expsum,
                           input logic expc, input string tag);
    int          lat;
    logic [31:0] got;
    sw_a = x; sw_b = y; sw_start[idx] = 1'b1;
    tick();
    sw_start[idx] = 1'b0;
    lat = 0;
    while (!sw_done[idx] && lat < 100) begin
      tick();
      lat++;
    end
    case (idx)
      0:       got = sum_c1;
      1:       got = sum_c4;
      2:       got = sum_c32;
      default: got = {16'h0, sum_w16};
    endcase
    chk({tag, "_lat"}, lat, explat);
    chk({tag, "_sum"}, got, expsum);
    chk({tag, "_cout"}, sw_cout[idx], expc);
    tick();
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [33:0] e;

    rst = 1'b1; start = 1'b1; sub = 1'b0; cin = 1'b0;
    a = 32'h1234; b = 32'h5678;
    sw_start = '0; sw_a = '0; sw_b = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("rst_start_ignored", busy, 0);

    run_main(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, "wrap");
    chk("wrap_const_sum", sum, 32'h0);
    chk("wrap_const_cout", cout, 1);
    run_main(32'd2, 32'd5, 1'b1, 1'b0, "cin");
    chk("cin_const_sum", sum, 32'd8);
    run_main(32'd100, 32'd200, 1'b0, 1'b1, "sub_neg");
    chk("sub_neg_const", sum, 32'hFFFF_FF9C);
    run_main(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, "add_ovf");
    chk("add_ovf_const", ovf, 1);
    run_main(32'h8000_0000, 32'h1, 1'b0, 1'b1, "sub_ovf");
    chk("sub_ovf_const", sum, 32'h7FFF_FFFF);

    // Start pulsed mid-run with other operands must be ignored.
    a = 32'd1000; b = 32'd2000; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 32'd7; b = 32'd9; sub = 1'b1; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    chk("midrun_lat", lat, 2);
    chk("midrun_sum", sum, 32'd3000);
    tick();
    chk("midrun_no_restart", busy, 0);

    // Start held through the done cycle is accepted on the following edge.
    a = 32'd10; b = 32'd20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    a = 32'd25; b = 32'd30;
    wait_done(lat);
    chk("hold_first_sum", sum, 32'd30);
    tick();
    start = 1'b0;
    chk("hold_accept_busy", busy, 1);
    chk("hold_accept_done", done, 0);
    chk("hold_old_sum", sum, 32'd30);
    wait_done(lat);
    chk("hold_lat", lat, 4);
    chk("hold_new_sum", sum, 32'd55);
    tick();

    // Reset in the middle of a run aborts it.
    a = 32'd15520; b = 32'd35000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_flags", {done, cout, ovf}, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_main(32'd15520, 32'd35000, 1'b0, 1'b0, "restart");
    chk("restart_const", sum, 32'd50520);

    for (int i = 0; i < 16; i++) begin
      run_main($urandom, $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end
    e = ref_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_main(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "neg_ovf");
    chk("neg_ovf_model", e[33], 1);

    run_sweep(0, 32'd15520, 32'd35000, 32, 32'd50520, 1'b0, "c1");
    run_sweep(1, 32'd15520, 32'd35000, 8, 32'd50520, 1'b0, "c4");
    run_sweep(2, 32'd15520, 32'd35000, 1, 32'd50520, 1'b0, "c32");
    run_sweep(3, 32'h0000_FFFF, 32'h5, 4, 32'd4, 1'b1, "w16");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
